syscall_unit: RTL and testbench

- Synchronous syscall service controller for the pipelined MIPS CPU. Driven from WB-stage SYSCALL decode.
- Decodes the service number in $v0 and handles three services: exit, print-hex and print-decimal.
- Buffers print arguments ($a0) in a small FIFO feeding the display driver, which reads them via valid/ready.
- Generates the pipeline halt: on exit, on FIFO-full back-pressure, and optionally a single-step pause released by the GO button.

---
 rtl/syscall_unit.sv | 169 ++++++++++++++++
 tb/tb_syscall_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/syscall_unit.sv
// Syscall service controller for the pipelined MIPS CPU.
// Decodes $v0 at WB-stage SYSCALL retirement and handles three services:
// exit, print-hex and print-decimal. Print arguments are queued in a small
// FIFO that the display driver drains through a valid/ready handshake. The
// unit also drives the pipeline halt for exit, for FIFO back-pressure, and
// for an optional single-step pause that the GO button releases.
module syscall_unit #(
  parameter int DATA_W           = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int SVC_EXIT         = 10,
  parameter int SVC_PRINT_HEX    = 34,
  parameter int SVC_PRINT_DEC    = 1,
  parameter int PAUSE_ON_SYSCALL = 1,
  parameter int CNT_W            = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              SYSCALL,
  input  logic              GO,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              halt,
  output logic [DATA_W-1:0] dout,
  output logic              dout_mode,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] display,
  output logic              exited,
  output logic [CNT_W-1:0]  syscall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] V_EXIT = DATA_W'(SVC_EXIT);
  localparam logic [DATA_W-1:0] V_HEX  = DATA_W'(SVC_PRINT_HEX);
  localparam logic [DATA_W-1:0] V_DEC  = DATA_W'(SVC_PRINT_DEC);

  typedef enum logic [1:0] {RUN, PAUSE, FULL_WAIT, EXIT} state_t;

  state_t             state_q, state_d;
  logic               halt_q, halt_d;
  logic               exited_q, exited_d;
  logic               go_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W:0]     wptr_q, wptr_d;
  logic [PTR_W:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0]  display_q, display_d;
  logic [DATA_W-1:0]  pend_data_q, pend_data_d;
  logic               pend_mode_q, pend_mode_d;

  logic [DATA_W-1:0]  mem_data_q [FIFO_DEPTH];
  logic               mem_mode_q [FIFO_DEPTH];

  logic               go_rise, full, empty, pop, can_push;
  logic               is_exit, is_hex, is_dec, is_print;
  logic               push;
  logic [DATA_W-1:0]  push_data;
  logic               push_mode;
  state_t             after_svc;

  assign go_rise  = GO & ~go_q;
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                    (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign pop      = ~empty & dout_ready;
  // A pop on the same edge frees the head slot, so a push can land even when full.
  assign can_push = ~full | pop;

  assign is_exit  = (v0 == V_EXIT);
  assign is_hex   = (v0 == V_HEX);
  assign is_dec   = (v0 == V_DEC);
  assign is_print = is_hex | is_dec;
  assign after_svc = (PAUSE_ON_SYSCALL != 0) ? PAUSE : RUN;

  // Service decode, FIFO pointer update and next-state selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    push_data   = a0;
    push_mode   = is_dec;
    pend_data_d = pend_data_q;
    pend_mode_d = pend_mode_q;
    case (state_q)
      RUN: begin
        if (SYSCALL) begin
          if (is_exit) begin
            state_d = EXIT;
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (is_print) begin
            if (can_push) begin
              push    = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              state_d = after_svc;
            end else begin
              pend_data_d = a0;
              pend_mode_d = is_dec;
              state_d     = FULL_WAIT;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = after_svc;
          end
        end
      end
      FULL_WAIT: begin
        push_data = pend_data_q;
        push_mode = pend_mode_q;
        if (can_push) begin
          push    = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = after_svc;
        end
      end
      PAUSE: begin
        if (go_rise) state_d = RUN;
      end
      default: state_d = EXIT;
    endcase

    wptr_d    = push ? wptr_q + (PTR_W+1)'(1) : wptr_q;
    rptr_d    = pop  ? rptr_q + (PTR_W+1)'(1) : rptr_q;
    display_d = pop  ? dout : display_q;
    halt_d    = (state_d != RUN);
    exited_d  = (state_d == EXIT);
  end

  // Control state, pointers, counters and registered status outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= RUN;
      halt_q    <= 1'b0;
      exited_q  <= 1'b0;
      go_q      <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      display_q <= '0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      exited_q  <= exited_d;
      go_q      <= GO;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      display_q <= display_d;
    end
  end

  // FIFO storage and the held-back entry; contents are meaningless while empty/idle.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data_q[wptr_q[PTR_W-1:0]] <= push_data;
      mem_mode_q[wptr_q[PTR_W-1:0]] <= push_mode;
    end
    pend_data_q <= pend_data_d;
    pend_mode_q <= pend_mode_d;
  end

  // Head is masked while empty so stale storage never reaches the display path.
  assign dout        = empty ? '0   : mem_data_q[rptr_q[PTR_W-1:0]];
  assign dout_mode   = empty ? 1'b0 : mem_mode_q[rptr_q[PTR_W-1:0]];
  assign dout_valid  = ~empty;
  assign halt        = halt_q;
  assign exited      = exited_q;
  assign display     = display_q;
  assign syscall_cnt = cnt_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: instance A pauses on every syscall,
// instance B runs without pausing; both share clock, reset and inputs.
module tb_syscall_unit;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        SYSCALL = 1'b0;
  logic        GO = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        dout_ready = 1'b0;

  logic        halt_a, dout_mode_a, dout_valid_a, exited_a;
  logic [31:0] dout_a, display_a;
  logic [15:0] cnt_a;
  logic        halt_b, dout_mode_b, dout_valid_b, exited_b;
  logic [31:0] dout_b, display_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  syscall_unit #(.PAUSE_ON_SYSCALL(1)) dut_a (
    .CLK(CLK), .CLR(CLR), .SYSCALL(SYSCALL), .GO(GO), .v0(v0), .a0(a0),
    .halt(halt_a), .dout(dout_a), .dout_mode(dout_mode_a), .dout_valid(dout_valid_a),
    .dout_ready(dout_ready), .display(display_a), .exited(exited_a), .syscall_cnt(cnt_a)
  );

  syscall_unit #(.PAUSE_ON_SYSCALL(0)) dut_b (
    .CLK(CLK), .CLR(CLR), .SYSCALL(SYSCALL), .GO(GO), .v0(v0), .a0(a0),
    .halt(halt_b), .dout(dout_b), .dout_mode(dout_mode_b), .dout_valid(dout_valid_b),
    .dout_ready(dout_ready), .display(display_b), .exited(exited_b), .syscall_cnt(cnt_b)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_sys(input logic [31:0] v, input logic [31:0] a);
    v0 = v; a0 = a; SYSCALL = 1'b1;
    tick();
    SYSCALL = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    tick(); tick();
    CLR = 1'b0;
    #1;
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b want 0", halt_a); end
    n_checks++; if (exited_a !== 1'b0) begin n_fail++; $display("FAIL rst_exited: got %b want 0", exited_a); end
    n_checks++; if (dout_valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", dout_valid_a); end
    n_checks++; if (dout_a !== 32'h0) begin n_fail++; $display("FAIL rst_dout: got %h want 0", dout_a); end
    n_checks++; if (dout_mode_a !== 1'b0) begin n_fail++; $display("FAIL rst_mode: got %b want 0", dout_mode_a); end
    n_checks++; if (display_a !== 32'h0) begin n_fail++; $display("FAIL rst_display: got %h want 0", display_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt_a); end
  endtask

  task automatic test_print_pause();
    tick();
    do_sys(32'd34, 32'h1234ABCD);
    n_checks++; if (dout_valid_a !== 1'b1) begin n_fail++; $display("FAIL hex_valid: got %b want 1", dout_valid_a); end
    n_checks++; if (dout_a !== 32'h1234ABCD) begin n_fail++; $display("FAIL hex_dout: got %h want 1234abcd", dout_a); end
    n_checks++; if (dout_mode_a !== 1'b0) begin n_fail++; $display("FAIL hex_mode: got %b want 0", dout_mode_a); end
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL hex_halt: got %b want 1", halt_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL hex_cnt: got %0d want 1", cnt_a); end
    tick();
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL pause_hold: got %b want 1", halt_a); end
    GO = 1'b1;
    tick();
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL go_release: got %b want 0", halt_a); end
    for (int i = 0; i < 10; i++) tick();
    // GO still held: an unknown service must pause and stay paused.
    do_sys(32'd7, 32'hDEAD0000);
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL unk_halt: got %b want 1", halt_a); end
    n_checks++; if (cnt_a !== 16'd2) begin n_fail++; $display("FAIL unk_cnt: got %0d want 2", cnt_a); end
    n_checks++; if (dout_a !== 32'h1234ABCD) begin n_fail++; $display("FAIL unk_nopush: got %h want 1234abcd", dout_a); end
    tick(); tick(); tick();
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL go_level: got %b want 1", halt_a); end
    GO = 1'b0;
    tick();
    GO = 1'b1;
    tick();
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL unk_release: got %b want 0", halt_a); end
    GO = 1'b0;
    tick();
  endtask

  task automatic test_pop();
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_checks++; if (display_a !== 32'h1234ABCD) begin n_fail++; $display("FAIL pop_display: got %h want 1234abcd", display_a); end
    n_checks++; if (dout_valid_a !== 1'b0) begin n_fail++; $display("FAIL pop_valid: got %b want 0", dout_valid_a); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_checks++; if (display_a !== 32'h1234ABCD) begin n_fail++; $display("FAIL pop_empty: got %h want 1234abcd", display_a); end
    do_sys(32'd1, 32'd42);
    n_checks++; if (dout_mode_a !== 1'b1) begin n_fail++; $display("FAIL dec_mode: got %b want 1", dout_mode_a); end
    n_checks++; if (dout_a !== 32'd42) begin n_fail++; $display("FAIL dec_dout: got %0d want 42", dout_a); end
    n_checks++; if (cnt_a !== 16'd3) begin n_fail++; $display("FAIL dec_cnt: got %0d want 3", cnt_a); end
    GO = 1'b1; tick(); GO = 1'b0; tick();
  endtask

  task automatic test_fill();
    logic [31:0] exp;
    pulse_clr();
    for (int i = 1; i <= 4; i++) begin
      do_sys(32'd34, 32'(i));
      tick();
    end
    n_checks++; if (halt_b !== 1'b0) begin n_fail++; $display("FAIL fill4_halt: got %b want 0", halt_b); end
    n_checks++; if (cnt_b !== 16'd4) begin n_fail++; $display("FAIL fill4_cnt: got %0d want 4", cnt_b); end
    do_sys(32'd34, 32'd5);
    n_checks++; if (halt_b !== 1'b1) begin n_fail++; $display("FAIL full_halt: got %b want 1", halt_b); end
    n_checks++; if (cnt_b !== 16'd4) begin n_fail++; $display("FAIL full_cnt: got %0d want 4", cnt_b); end
    tick(); tick();
    n_checks++; if (halt_b !== 1'b1) begin n_fail++; $display("FAIL full_wait: got %b want 1", halt_b); end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    n_checks++; if (display_b !== 32'd1) begin n_fail++; $display("FAIL fw_display: got %0d want 1", display_b); end
    n_checks++; if (cnt_b !== 16'd5) begin n_fail++; $display("FAIL fw_cnt: got %0d want 5", cnt_b); end
    n_checks++; if (halt_b !== 1'b0) begin n_fail++; $display("FAIL fw_halt: got %b want 0", halt_b); end
    for (int i = 2; i <= 5; i++) begin
      exp = 32'(i);
      n_checks++; if (dout_b !== exp) begin n_fail++; $display("FAIL drain_head: got %0d want %0d", dout_b, exp); end
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      n_checks++; if (display_b !== exp) begin n_fail++; $display("FAIL drain_display: got %0d want %0d", display_b, exp); end
    end
    n_checks++; if (dout_valid_b !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", dout_valid_b); end
  endtask

  task automatic test_exit();
    pulse_clr();
    do_sys(32'd10, 32'd0);
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL exit_halt: got %b want 1", halt_a); end
    n_checks++; if (exited_a !== 1'b1) begin n_fail++; $display("FAIL exit_flag: got %b want 1", exited_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL exit_cnt: got %0d want 1", cnt_a); end
    GO = 1'b1; tick(); GO = 1'b0; tick();
    do_sys(32'd34, 32'h55);
    tick();
    n_checks++; if (halt_a !== 1'b1) begin n_fail++; $display("FAIL exit_stuck: got %b want 1", halt_a); end
    n_checks++; if (cnt_a !== 16'd1) begin n_fail++; $display("FAIL exit_cnt_hold: got %0d want 1", cnt_a); end
    n_checks++; if (dout_valid_a !== 1'b0) begin n_fail++; $display("FAIL exit_nopush: got %b want 0", dout_valid_a); end
    pulse_clr();
    n_checks++; if (halt_a !== 1'b0) begin n_fail++; $display("FAIL exit_clr_halt: got %b want 0", halt_a); end
    n_checks++; if (exited_a !== 1'b0) begin n_fail++; $display("FAIL exit_clr_flag: got %b want 0", exited_a); end
    n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL exit_clr_cnt: got %0d want 0", cnt_a); end
  endtask

  task automatic test_async_clr();
    pulse_clr();
    do_sys(32'd34, 32'd1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      do_sys(32'd34, 32'(i));
      tick();
    end
    do_sys(32'd34, 32'd6);
    n_checks++; if (halt_b !== 1'b1) begin n_fail++; $display("FAIL ac_pre_halt: got %b want 1", halt_b); end
    n_checks++; if (display_b !== 32'd1) begin n_fail++; $display("FAIL ac_pre_display: got %0d want 1", display_b); end
    #2;
    CLR = 1'b1;
    #1;
    n_checks++; if (dout_valid_b !== 1'b0) begin n_fail++; $display("FAIL ac_valid: got %b want 0", dout_valid_b); end
    n_checks++; if (halt_b !== 1'b0) begin n_fail++; $display("FAIL ac_halt: got %b want 0", halt_b); end
    n_checks++; if (display_b !== 32'd0) begin n_fail++; $display("FAIL ac_display: got %0d want 0", display_b); end
    n_checks++; if (cnt_b !== 16'd0) begin n_fail++; $display("FAIL ac_cnt: got %0d want 0", cnt_b); end
    n_checks++; if (dout_b !== 32'd0) begin n_fail++; $display("FAIL ac_dout: got %h want 0", dout_b); end
    tick();
    CLR = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (dout_valid_b !== 1'b0) begin n_fail++; $display("FAIL ac_discard: got %b want 0", dout_valid_b); end
    n_checks++; if (halt_b !== 1'b0) begin n_fail++; $display("FAIL ac_run: got %b want 0", halt_b); end
  endtask

  initial begin
    test_reset();
    test_print_pause();
    test_pop();
    test_fill();
    test_exit();
    test_async_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
